// File: rtl/adc_reg_readback.sv
// SPI read of one 16-bit ADC register: 24-bit frame {1, addr[6:0], data[15:0]}, MSB first.
// Optional build macro ADC_RD_MISO_SYNC_EN adds a 2-flop MISO synchronizer (CLK_DIV >= 6).
module adc_reg_readback #(
  parameter int CLK_DIV = 20
) (
  input  logic        adc_set_clk,
  input  logic        rst,
  input  logic        rd_start,
  input  logic [6:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        ADC_SCLK,
  output logic        ADC_CSN,
  output logic        ADC_MOSI,
  input  logic        ADC_MISO,
  output logic [2:0]  state_dbg
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  // Handshake: rd_start is honoured only in IDLE (busy=0); while busy=1 it is
  // ignored. rd_valid pulses for one cycle when rd_data takes a new value.
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_cnt;
  logic [22:0]   tx_sr;
  logic [15:0]   rx_sr;
  logic          half_done;
  logic          cap_edge;

  assign state_dbg = state;
  assign half_done = (cnt == HALF_LAST);

  // This edge drives SCLK 0->1 into one of periods 9..24 (bit_cnt holds period-1).
  assign cap_edge = (state == SHIFT) && !ADC_SCLK && half_done &&
                    (bit_cnt >= 5'd7) && (bit_cnt != 5'd23);

`ifdef ADC_RD_MISO_SYNC_EN
  logic miso_s1, miso_s2;
  logic cap_p1, cap_p2;

  // Capture is delayed two cycles to line up with the synchronized sample.
  always_ff @(posedge adc_set_clk) begin
    if (rst) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
      cap_p1  <= 1'b0;
      cap_p2  <= 1'b0;
      rx_sr   <= 16'h0000;
    end else begin
      miso_s1 <= ADC_MISO;
      miso_s2 <= miso_s1;
      cap_p1  <= cap_edge;
      cap_p2  <= cap_p1;
      if (cap_p2) rx_sr <= {rx_sr[14:0], miso_s2};
    end
  end
`else
  always_ff @(posedge adc_set_clk) begin
    if (rst) begin
      rx_sr <= 16'h0000;
    end else if (cap_edge) begin
      rx_sr <= {rx_sr[14:0], ADC_MISO};
    end
  end
`endif

  always_ff @(posedge adc_set_clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= 5'd0;
      tx_sr    <= 23'h0;
      rd_data  <= 16'h0000;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      ADC_SCLK <= 1'b0;
      ADC_CSN  <= 1'b1;
      ADC_MOSI <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_start) begin
            tx_sr    <= {rd_addr, 16'h0000};
            busy     <= 1'b1;
            ADC_CSN  <= 1'b0;
            ADC_MOSI <= 1'b1;
            cnt      <= '0;
            bit_cnt  <= 5'd0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (half_done) begin
            cnt      <= '0;
            ADC_SCLK <= 1'b1;
            state    <= SHIFT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHIFT: begin
          if (!half_done) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt <= '0;
            if (ADC_SCLK) begin
              // Falling edge: present the next bit; the zero-filled tail leaves MOSI low.
              ADC_SCLK <= 1'b0;
              ADC_MOSI <= tx_sr[22];
              tx_sr    <= {tx_sr[21:0], 1'b0};
            end else if (bit_cnt == 5'd23) begin
              state <= HOLD;
            end else begin
              ADC_SCLK <= 1'b1;
              bit_cnt  <= bit_cnt + 5'd1;
            end
          end
        end
        HOLD: begin
          if (half_done) begin
            cnt      <= '0;
            ADC_CSN  <= 1'b1;
            rd_data  <= rx_sr;
            rd_valid <= 1'b1;
            state    <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (half_done) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_reg_readback.sv
// Scoreboard bench for adc_reg_readback: driver tasks push expected command bytes and
// read data; an ADC model answers on MISO and monitors check frames and rd_valid.
module tb_adc_reg_readback;

`ifdef ADC_RD_MISO_SYNC_EN
  localparam int CLK_DIV = 6;
`else
  localparam int CLK_DIV = 20;
`endif
  localparam int HALF = CLK_DIV / 2;

  logic        adc_set_clk;
  logic        rst;
  logic        rd_start;
  logic [6:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        ADC_SCLK;
  logic        ADC_CSN;
  logic        ADC_MOSI;
  logic        ADC_MISO;
  logic [2:0]  state_dbg;

  adc_reg_readback #(.CLK_DIV(CLK_DIV)) dut (
    .adc_set_clk(adc_set_clk),
    .rst        (rst),
    .rd_start   (rd_start),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .ADC_SCLK   (ADC_SCLK),
    .ADC_CSN    (ADC_CSN),
    .ADC_MOSI   (ADC_MOSI),
    .ADC_MISO   (ADC_MISO),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial adc_set_clk = 1'b0;
  always #5 adc_set_clk = ~adc_set_clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  cmd_q[$];
  logic [15:0] model_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ADC model: shifts data bits 15..0 out after SCLK falls 8..23 of the frame.
  logic [15:0] cur_word;
  int          fall_cnt;
  logic        m_prev_sclk, m_prev_csn;
  initial begin
    ADC_MISO = 1'b0; cur_word = 16'h0; fall_cnt = 0;
    m_prev_sclk = 1'b0; m_prev_csn = 1'b1;
  end
  always @(posedge adc_set_clk) begin
    #1;
    if (m_prev_csn === 1'b1 && ADC_CSN === 1'b0) begin
      fall_cnt = 0;
      ADC_MISO = 1'b0;
      cur_word = (model_q.size() > 0) ? model_q.pop_front() : 16'h0;
    end else if (ADC_CSN === 1'b0 && m_prev_sclk === 1'b1 && ADC_SCLK === 1'b0) begin
      fall_cnt++;
      if (fall_cnt >= 8 && fall_cnt <= 23) ADC_MISO = cur_word[23 - fall_cnt];
    end
    m_prev_sclk = ADC_SCLK;
    m_prev_csn  = ADC_CSN;
  end

  // Frame monitor: command byte, CSN low time, SCLK count, MOSI tail, busy fall.
  bit         in_frame = 0, gap_on = 0, f_prev_sclk = 0;
  int         low_cnt = 0, rise_cnt = 0, data_ones = 0, gap_cnt = 0;
  logic [7:0] cmd_bits = 8'h0;
  logic [7:0] cmd_exp;
  always @(negedge adc_set_clk) begin
    if (rst) begin
      in_frame = 0; gap_on = 0; f_prev_sclk = 0;
    end else begin
      if (!ADC_CSN) begin
        if (!in_frame) begin
          in_frame = 1; low_cnt = 0; rise_cnt = 0; data_ones = 0; cmd_bits = 8'h0;
        end
        low_cnt++;
        if (ADC_SCLK && !f_prev_sclk) begin
          rise_cnt++;
          if (rise_cnt <= 8) cmd_bits = {cmd_bits[6:0], ADC_MOSI};
          else if (ADC_MOSI) data_ones++;
          if (rise_cnt == 8) begin
            if (cmd_q.size() == 0) check("cmd_unexpected", 32'(cmd_bits), 32'hFFFF_FFFF);
            else begin
              cmd_exp = cmd_q.pop_front();
              check("cmd_byte", 32'(cmd_bits), 32'(cmd_exp));
            end
          end
        end
      end else if (in_frame) begin
        in_frame = 0;
        check("csn_low_cycles", 32'(low_cnt), 32'(50 * HALF));
        check("sclk_rises", 32'(rise_cnt), 32'd24);
        check("mosi_tail_zero", 32'(data_ones), 32'd0);
        gap_on = 1; gap_cnt = 0;
      end
      if (gap_on) begin
        if (busy) gap_cnt++;
        else begin
          check("busy_fall_delay", 32'(gap_cnt), 32'(HALF));
          gap_on = 0;
        end
      end
      f_prev_sclk = ADC_SCLK;
    end
  end

  // Scoreboard monitor: every rd_valid pops one expected word.
  int          valid_cnt = 0;
  bit          prev_valid = 0;
  logic [15:0] exp_word;
  always @(negedge adc_set_clk) begin
    if (rd_valid) begin
      valid_cnt++;
      check("valid_one_cycle", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) check("valid_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
      else begin
        exp_word = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(exp_word));
      end
    end
    prev_valid = rd_valid;
  end

  // driver tasks (called and returning on a negedge)
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge adc_set_clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue_read(input logic [6:0] a, input logic [15:0] d, input bit exp_valid);
    wait_idle();
    cmd_q.push_back({1'b1, a});
    model_q.push_back(d);
    if (exp_valid) exp_q.push_back(d);
    rd_addr  = a;
    rd_start = 1'b1;
    @(negedge adc_set_clk);
    rd_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  int v0;
  int n;

  initial begin
    rst = 1'b1; rd_start = 1'b1; rd_addr = 7'h55;
    repeat (3) @(negedge adc_set_clk);
    // reset dominates a simultaneous rd_start
    check("rst_csn", 32'(ADC_CSN), 32'd1);
    check("rst_sclk", 32'(ADC_SCLK), 32'd0);
    check("rst_mosi", 32'(ADC_MOSI), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'h0000);
    check("rst_state_idle", 32'(state_dbg), 32'd0);
    rd_start = 1'b0;
    rst = 1'b0;
    @(negedge adc_set_clk);

    // single read: command 0x85, data 0xA5C3
    issue_read(7'h05, 16'hA5C3, 1'b1);
    // back-to-back extremes: commands 0xFF then 0x80
    issue_read(7'h7F, 16'hFFFF, 1'b1);
    issue_read(7'h00, 16'h0001, 1'b1);

    // rd_start held every cycle during a frame produces one frame only
    issue_read(7'h12, 16'h1234, 1'b1);
    v0 = valid_cnt;
    rd_addr = 7'h33;
    n = 0;
    while (busy && n < 2000) begin
      rd_start = 1'b1;
      @(negedge adc_set_clk);
      n++;
    end
    rd_start = 1'b0;
    check("repeat_start_one_valid", 32'(valid_cnt - v0), 32'd1);
    issue_read(7'h40, 16'h8001, 1'b1);

    // abort in the 12th SCLK period, with rd_start asserted alongside rst
    issue_read(7'h2A, 16'h5555, 1'b0);
    n = 0;
    while (rise_cnt != 12 && n < 2000) begin
      @(negedge adc_set_clk);
      #1;
      n++;
    end
    check("abort_reached_p12", 32'(rise_cnt), 32'd12);
    v0 = valid_cnt;
    rst = 1'b1; rd_start = 1'b1; rd_addr = 7'h11;
    @(posedge adc_set_clk);
    #1;
    check("abort_csn", 32'(ADC_CSN), 32'd1);
    check("abort_sclk", 32'(ADC_SCLK), 32'd0);
    check("abort_valid", 32'(rd_valid), 32'd0);
    check("abort_data", 32'(rd_data), 32'h0000);
    @(negedge adc_set_clk);
    rd_start = 1'b0;
    @(negedge adc_set_clk);
    rst = 1'b0;
    repeat (60 * HALF) @(negedge adc_set_clk);
    check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_csn", 32'(ADC_CSN), 32'd1);
    check("abort_data_held", 32'(rd_data), 32'h0000);

    // recovery read after the abort
    issue_read(7'h3C, 16'h0F0F, 1'b1);
    wait_idle();
    repeat (4) @(negedge adc_set_clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    check("final_state_idle", 32'(state_dbg), 32'd0);
    check("final_data", 32'(rd_data), 32'h0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
